// File: rtl/packet_uart_dump.sv
// Packet capture and UART 8N1 dump: frames captured sniffer packets as [SYNC][LEN][payload].
// Define PKT_DUMP_CHECKSUM_EN to append an XOR checksum byte (LEN and payload) to each frame.
module packet_uart_dump #(
   parameter int          PACKET_BITS  = 368,
   parameter int          CLKS_PER_BIT = 139,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int          DROP_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   packet_detected,
   input  logic [PACKET_BITS-1:0] packet_out,
   input  logic [8:0]             packet_len,
   output logic                   uart_tx,
   output logic                   busy,
   output logic [DROP_W-1:0]      drop_count,
   output logic [2:0]             state_dbg
);

   localparam int MAX_BYTES = PACKET_BITS / 8;
   localparam int BYTE_W    = $clog2(MAX_BYTES + 1);
   localparam int CNT_W     = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CSUM    = 3'd4
   } state_t;

   state_t                 state;
   logic                   s1, s2, s3;
   logic [PACKET_BITS-1:0] shadow_data;
   logic [BYTE_W-1:0]      n_bytes;
   logic [BYTE_W-1:0]      byte_idx;
   logic [7:0]             shift;
   logic [3:0]             bit_idx;
   logic [CNT_W-1:0]       clk_cnt;
`ifdef PKT_DUMP_CHECKSUM_EN
   logic [7:0]             csum;
`endif

   logic                   rise;
   logic                   bit_end;
   logic                   last_byte;
   logic                   frame_end;
   logic                   capture;
   logic [BYTE_W-1:0]      next_idx;
   logic [7:0]             pay_next;
   logic [9:0]             len_plus;
   logic [6:0]             n_raw;
   logic [BYTE_W-1:0]      n_next;

   assign state_dbg = state;
   assign rise      = s2 & ~s3;
   assign bit_end   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

   // Byte count is ceil(len/8), clamped to what packet_out can actually hold.
   always_comb begin
      len_plus = {1'b0, packet_len} + 10'd7;
      n_raw    = len_plus[9:3];
      n_next   = (n_raw > 7'(MAX_BYTES)) ? BYTE_W'(MAX_BYTES) : n_raw[BYTE_W-1:0];
   end

   always_comb begin
      next_idx = byte_idx + 1'b1;
      pay_next = shadow_data[{next_idx, 3'b000} +: 8];
`ifdef PKT_DUMP_CHECKSUM_EN
      last_byte = (state == CSUM);
`else
      last_byte = ((state == LEN) && (n_bytes == '0)) ||
                  ((state == PAYLOAD) && (next_idx == n_bytes));
`endif
      frame_end = (state != IDLE) && bit_end && (bit_idx == 4'd9) && last_byte;
      // A rise on the closing edge of a frame starts the next frame without a gap.
      capture   = rise && ((state == IDLE) || frame_end);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         shadow_data <= '0;
         n_bytes     <= '0;
         byte_idx    <= '0;
         shift       <= '0;
         bit_idx     <= '0;
         clk_cnt     <= '0;
         uart_tx     <= 1'b1;
         busy        <= 1'b0;
         drop_count  <= '0;
`ifdef PKT_DUMP_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         s1 <= packet_detected;
         s2 <= s1;
         s3 <= s2;

         if (rise && busy && !frame_end && (drop_count != {DROP_W{1'b1}}))
            drop_count <= drop_count + 1'b1;

         if (capture) begin
            shadow_data <= packet_out;
            n_bytes     <= n_next;
            state       <= SYNC;
            busy        <= 1'b1;
            shift       <= SYNC_BYTE;
            uart_tx     <= 1'b0;
            bit_idx     <= '0;
            clk_cnt     <= '0;
         end else if (frame_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            uart_tx <= 1'b1;
            bit_idx <= '0;
            clk_cnt <= '0;
         end else if (state != IDLE) begin
            if (!bit_end) begin
               clk_cnt <= clk_cnt + 1'b1;
            end else begin
               clk_cnt <= '0;
               if (bit_idx != 4'd9) begin
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 4'd8) begin
                     uart_tx <= 1'b1;
                  end else begin
                     uart_tx <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end else begin
                  // Stop bit done and more bytes remain: next start bit begins now.
                  bit_idx <= '0;
                  uart_tx <= 1'b0;
                  case (state)
                     SYNC: begin
                        state <= LEN;
                        shift <= 8'(n_bytes);
`ifdef PKT_DUMP_CHECKSUM_EN
                        csum  <= 8'(n_bytes);
`endif
                     end
                     LEN: begin
`ifdef PKT_DUMP_CHECKSUM_EN
                        if (n_bytes == '0) begin
                           state <= CSUM;
                           shift <= csum;
                        end else
`endif
                        begin
                           state    <= PAYLOAD;
                           byte_idx <= '0;
                           shift    <= shadow_data[7:0];
`ifdef PKT_DUMP_CHECKSUM_EN
                           csum     <= csum ^ shadow_data[7:0];
`endif
                        end
                     end
                     PAYLOAD: begin
`ifdef PKT_DUMP_CHECKSUM_EN
                        if (next_idx == n_bytes) begin
                           state <= CSUM;
                           shift <= csum;
                        end else
`endif
                        begin
                           byte_idx <= next_idx;
                           shift    <= pay_next;
`ifdef PKT_DUMP_CHECKSUM_EN
                           csum     <= csum ^ pay_next;
`endif
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_packet_uart_dump.sv
// Directed bench for packet_uart_dump: decodes the UART line and checks frames, timing and drops.
module tb_packet_uart_dump;

   localparam int PB        = 368;
   localparam int CPB       = 8;
   localparam int BYTE_CLKS = 10 * CPB;
`ifdef PKT_DUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          packet_detected = 1'b0;
   logic [PB-1:0] packet_out = '0;
   logic [8:0]    packet_len = '0;
   logic          uart_tx;
   logic          busy;
   logic [7:0]    drop_count;
   logic [2:0]    state_dbg;

   packet_uart_dump #(
      .PACKET_BITS (PB),
      .CLKS_PER_BIT(CPB),
      .SYNC_BYTE   (8'hA5),
      .DROP_W      (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .packet_detected(packet_detected),
      .packet_out     (packet_out),
      .packet_len     (packet_len),
      .uart_tx        (uart_tx),
      .busy           (busy),
      .drop_count     (drop_count),
      .state_dbg      (state_dbg)
   );

   // clock/reset block
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_falls = 0;
   int unsigned payload_cycles = 0;
   logic        busy_q = 1'b0;
   always @(negedge clk) begin
      busy_q <= busy;
      if (busy_q && !busy) n_falls <= n_falls + 1;
      if (state_dbg == 3'd3) payload_cycles <= payload_cycles + 1;
   end

   // scoreboard
   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_exp(input logic [PB-1:0] data, input logic [8:0] len);
      int         n;
      logic [7:0] cs;
      logic [7:0] b;
      n = (int'(len) + 7) / 8;
      if (n > PB / 8) n = PB / 8;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(n));
      cs = 8'(n);
      for (int k = 0; k < n; k++) begin
         b  = data[8*k +: 8];
         exp_q.push_back(b);
         cs = cs ^ b;
      end
      if (CS != 0) exp_q.push_back(cs);
   endtask

   // driver tasks
   task automatic pulse();
      @(negedge clk) packet_detected = 1'b1;
      @(negedge clk) packet_detected = 1'b0;
   endtask

   task automatic wait_busy(output int unsigned c);
      int t = 0;
      while (!busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("busy_rise", busy, 1);
      c = cyc;
   endtask

   task automatic wait_idle(output int unsigned c);
      int t = 0;
      while (busy && t < 60 * BYTE_CLKS) begin
         @(negedge clk);
         t++;
      end
      check("busy_fall", busy, 0);
      c = cyc;
   endtask

   task automatic recv_byte(output logic [7:0] b);
      int t = 0;
      b = '0;
      @(negedge clk);
      while (uart_tx !== 1'b0 && t < 20 * BYTE_CLKS) begin
         @(negedge clk);
         t++;
      end
      if (uart_tx !== 1'b0) begin
         check("rx_start_timeout", {31'b0, uart_tx}, 0);
         return;
      end
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      check("rx_stop_bit", uart_tx, 1);
   endtask

   task automatic recv_frame(input int nb);
      logic [7:0] b;
      rx_q.delete();
      for (int i = 0; i < nb; i++) begin
         recv_byte(b);
         rx_q.push_back(b);
      end
   endtask

   task automatic compare_frame(input string tag);
      int n;
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_byte"}, rx_q[i], exp_q[i]);
   endtask

   task automatic run_frame(input logic [PB-1:0] data, input logic [8:0] len,
                            input int drops, input int gap, input string tag);
      int unsigned c0, c1;
      exp_q.delete();
      build_exp(data, len);
      packet_out = data;
      packet_len = len;
      pulse();
      wait_busy(c0);
      packet_out = ~data;
      packet_len = ~len;
      fork
         recv_frame(exp_q.size());
         begin
            repeat (100) @(negedge clk);
            for (int i = 0; i < drops; i++) begin
               pulse();
               repeat (gap) @(negedge clk);
            end
         end
      join
      wait_idle(c1);
      check({tag, "_busy_clks"}, c1 - c0, exp_q.size() * BYTE_CLKS);
      compare_frame(tag);
   endtask

   logic [PB-1:0] pat_a, pat_b;
   int unsigned   c_cap, c_end, f0, p0, target;

   initial begin
      for (int k = 0; k < PB / 8; k++) begin
         pat_a[8*k +: 8] = 8'(k * 37 + 11);
         pat_b[8*k +: 8] = 8'(k * 13 + 5);
      end

      // reset state
      repeat (3) @(negedge clk);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_count, 0);
      check("rst_state", state_dbg, 0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);

      // latency and the 16-bit reference packet: A5 02 6B 7D
      exp_q.delete();
      build_exp({{(PB-16){1'b0}}, 16'h7D6B}, 9'd16);
      packet_out = {{(PB-16){1'b0}}, 16'h7D6B};
      packet_len = 9'd16;
      @(negedge clk) packet_detected = 1'b1;
      @(negedge clk) packet_detected = 1'b0;
      check("lat_e1_tx", uart_tx, 1);
      @(negedge clk);
      check("lat_e2_tx", uart_tx, 1);
      check("lat_e2_busy", busy, 0);
      @(negedge clk);
      check("lat_e3_tx", uart_tx, 0);
      check("lat_e3_busy", busy, 1);
      c_cap = cyc;
      packet_out = '1;
      packet_len = 9'd5;
      recv_frame(exp_q.size());
      wait_idle(c_end);
      check("len16_busy_clks", c_end - c_cap, (4 + CS) * BYTE_CLKS);
      compare_frame("len16");
      check("len16_hand_b2", exp_q[2], 8'h6B);
      check("len16_drop", drop_count, 0);

      // zero-length packet never enters PAYLOAD
      p0 = payload_cycles;
      run_frame(pat_b, 9'd0, 0, 0, "len0");
      check("len0_no_payload", payload_cycles - p0, 0);

      // oversize length clamps to 46 bytes, 3 drops while busy
      run_frame(pat_a, 9'd400, 3, 10, "len400");
      check("len400_len_byte", rx_q.size() > 1 ? rx_q[1] : 8'h00, 8'h2E);
      check("drop_3", drop_count, 3);

      // 300 pulses while busy saturate the drop counter
      run_frame(pat_b, 9'd400, 300, 0, "sat");
      check("drop_sat", drop_count, 8'hFF);

      // reset in the middle of D3 of the LEN byte
      packet_out = {{(PB-16){1'b0}}, 16'h7D6B};
      packet_len = 9'd16;
      pulse();
      wait_busy(c_cap);
      target = c_cap + BYTE_CLKS + 4 * CPB + CPB / 2;
      while (cyc < target) @(negedge clk);
      check("pre_rst_d3", uart_tx, 0);
      #1 rst = 1'b0;
      #1;
      check("midrst_uart_tx", uart_tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_drop", drop_count, 0);
      check("midrst_state", state_dbg, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_frame({{(PB-16){1'b0}}, 16'hC381}, 9'd16, 0, 0, "post_rst");

      // rise on the closing edge of a frame chains the next frame
      f0 = n_falls;
      exp_q.delete();
      build_exp({{(PB-16){1'b0}}, 16'h1234}, 9'd16);
      build_exp({{(PB-8){1'b0}}, 8'h3C}, 9'd8);
      packet_out = {{(PB-16){1'b0}}, 16'h1234};
      packet_len = 9'd16;
      pulse();
      wait_busy(c_cap);
      packet_out = {{(PB-8){1'b0}}, 8'h3C};
      packet_len = 9'd8;
      fork
         recv_frame(exp_q.size());
         begin
            target = c_cap + (4 + CS) * BYTE_CLKS - 3;
            while (cyc < target) @(negedge clk);
            packet_detected = 1'b1;
            @(negedge clk) packet_detected = 1'b0;
         end
      join
      wait_idle(c_end);
      check("chain_busy_clks", c_end - c_cap, (7 + 2 * CS) * BYTE_CLKS);
      check("chain_one_fall", n_falls - f0, 1);
      check("chain_drop", drop_count, 0);
      compare_frame("chain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
